// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: FSM state encoding and default sizing for the SPI burst sequencer
package spi_seq_pkg;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_DISCARD = 3'd4;
    localparam int DEFAULT_DEPTH   = 8;
    localparam int DEFAULT_AW      = 3;
    localparam int DEFAULT_TIMEOUT = 1024;
endpackage

// File: rtl/spi_seq_fifo.sv
// spi_seq_fifo: byte FIFO with occupancy level; flush empties it and overrides push/pop
module spi_seq_fifo import spi_seq_pkg::*; #(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    assign full    = level_q == (AW+1)'(DEPTH);
    assign empty   = level_q == '0;
    assign level   = level_q;
    assign head    = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // pointer/level update; pointers wrap naturally at DEPTH
    always_comb begin
        mem_d   = mem_q;
        wr_d    = flush ? '0 : wr_q + AW'(do_push);
        rd_d    = flush ? '0 : rd_q + AW'(do_pop);
        level_d = flush ? '0 : level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        if (do_push && !flush) mem_d[wr_q] = push_data;
    end

    // storage and pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end
endmodule

// File: rtl/spi_burst_sequencer.sv
// spi_burst_sequencer: TX/RX byte FIFOs feeding an SPI master core; SPI_SEQ_TIMEOUT_EN adds a reply timeout
module spi_burst_sequencer import spi_seq_pkg::*; #(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW
`ifdef SPI_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [7:0]    rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    input  logic          enable,
    input  logic          flush,
    output logic [7:0]    spi_data_in,
    output logic          spi_start,
    input  logic          spi_busy,
    input  logic          spi_new_data,
    input  logic [7:0]    spi_data_out,
    output logic [AW:0]   tx_level,
    output logic [AW:0]   rx_level,
    output logic          active,
    output logic          overflow,
    output logic          error
);
    logic [2:0] state_q, state_d;
    logic [7:0] spi_data_q, spi_data_d;
    logic       overflow_q, overflow_d;
    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic       tx_pop, rx_push, launch, tmo;
    logic [7:0] tx_head;

    spi_seq_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx (
        .clk(clk), .rst(rst), .flush(flush),
        .push(tx_valid), .push_data(tx_data), .pop(tx_pop),
        .head(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
    );

    spi_seq_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx (
        .clk(clk), .rst(rst), .flush(flush),
        .push(rx_push), .push_data(spi_data_out), .pop(rx_ready),
        .head(rx_data), .full(rx_full), .empty(rx_empty), .level(rx_level)
    );

    assign tx_ready    = !tx_full;
    assign rx_valid    = !rx_empty;
    assign tx_pop      = state_q == S_LOAD;
    assign rx_push     = state_q == S_WAIT && spi_new_data;
    assign spi_start   = state_q == S_START && !flush;
    assign spi_data_in = spi_data_q;
    assign active      = state_q != S_IDLE;
    assign overflow    = overflow_q;
    // a launch needs a byte to send and guaranteed room for its reply
    assign launch      = enable && !tx_empty && !rx_full && !spi_busy && !error && !flush;

    // transfer sequencing: launch, load byte, one-cycle start, await reply
    always_comb begin
        spi_data_d = (state_q == S_LOAD) ? tx_head : spi_data_q;
        overflow_d = !flush && (overflow_q || (tx_valid && tx_full));
        case (state_q)
            S_IDLE:    state_d = launch ? S_LOAD : S_IDLE;
            S_LOAD:    state_d = flush ? S_IDLE : S_START;
            S_START:   state_d = flush ? S_IDLE : S_WAIT;
            S_WAIT:    state_d = (spi_new_data || tmo) ? S_IDLE : flush ? S_DISCARD : S_WAIT;
            S_DISCARD: state_d = spi_new_data ? S_IDLE : S_DISCARD;
            default:   state_d = S_IDLE;
        endcase
    end

    // sequencer state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            spi_data_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            spi_data_q <= spi_data_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          error_q, error_d;

    assign tmo   = state_q == S_WAIT && !spi_new_data && cnt_q == CW'(TIMEOUT - 1);
    assign error = error_q;

    // cycles elapsed since spi_start; error holds until flush
    always_comb begin
        cnt_d   = (state_q == S_START) ? CW'(1) : cnt_q + 1'b1;
        error_d = !flush && (error_q || tmo);
    end

    // timeout registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            error_q <= error_d;
        end
    end
`else
    assign tmo   = 1'b0;
    assign error = 1'b0;
`endif
endmodule

// File: tb/tb_spi_burst_sequencer.sv
// tb_spi_burst_sequencer: scoreboard bench with a behavioural SPI core; SPI_SEQ_TIMEOUT_EN enables the timeout scenario
`timescale 1ns/1ps
module tb_spi_burst_sequencer;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic          enable = 1'b0;
    logic          flush = 1'b0;
    logic [7:0]    spi_data_in;
    logic          spi_start;
    logic          spi_busy;
    logic          spi_new_data;
    logic [7:0]    spi_data_out;
    logic [AW:0]   tx_level;
    logic [AW:0]   rx_level;
    logic          active;
    logic          overflow;
    logic          error;

    spi_burst_sequencer #(
        .DEPTH(DEPTH), .AW(AW)
`ifdef SPI_SEQ_TIMEOUT_EN
        , .TIMEOUT(16)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .enable(enable), .flush(flush),
        .spi_data_in(spi_data_in), .spi_start(spi_start), .spi_busy(spi_busy),
        .spi_new_data(spi_new_data), .spi_data_out(spi_data_out),
        .tx_level(tx_level), .rx_level(rx_level),
        .active(active), .overflow(overflow), .error(error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int starts = 0;
    int start_cyc = 0;
    int s0, n;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    int core_delay = 2;
    bit store_resp = 1;
    bit resp_77 = 0;
    bit core_hang = 0;
    bit prev_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: start pulses must carry queued TX bytes in order, RX pops the core replies in order
    always @(negedge clk) begin
        if (!rst) prev_start = 0;
        else begin
            if (spi_start) begin
                check("start_single_cycle", int'(prev_start), 0);
                starts++;
                start_cyc = cyc;
                check("start_has_queued_byte", int'(tx_exp.size() != 0), 1);
                if (tx_exp.size() != 0) check("spi_data_in", int'(spi_data_in), int'(tx_exp.pop_front()));
            end
            if (rx_valid && rx_ready) begin
                check("rx_has_expected_byte", int'(rx_exp.size() != 0), 1);
                if (rx_exp.size() != 0) check("rx_data", int'(rx_data), int'(rx_exp.pop_front()));
            end
            prev_start = spi_start;
        end
    end

    // SPI core model: replies ~byte (or 0x77) core_delay cycles after start, aborts on reset
    initial begin
        logic [7:0] b;
        bit ok;
        spi_busy = 0;
        spi_new_data = 0;
        spi_data_out = '0;
        forever begin
            @(negedge clk);
            if (rst && spi_start) begin
                b = spi_data_in;
                ok = !core_hang;
                spi_busy = 1;
                for (int i = 0; i < core_delay && ok; i++) begin
                    @(negedge clk);
                    if (!rst) ok = 0;
                end
                if (ok) begin
                    spi_data_out = resp_77 ? 8'h77 : ~b;
                    spi_new_data = 1;
                    if (store_resp) rx_exp.push_back(spi_data_out);
                    @(negedge clk);
                end
                spi_new_data = 0;
                spi_busy = 0;
            end
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        tx_valid = 1;
        tx_data = b;
        if (tx_exp.size() < DEPTH) tx_exp.push_back(b);
        step(1);
        tx_valid = 0;
    endtask

    task automatic wait_rx(input string name, input int lvl, input int budget);
        int k = 0;
        while (!(int'(rx_level) == lvl && !active && !spi_busy) && k < budget) begin
            step(1);
            k++;
        end
        check({name, "_in_time"}, int'(k < budget), 1);
    endtask

    task automatic drain(input string name);
        int k = 0;
        rx_ready = 1;
        while (rx_valid && k < 50) begin
            step(1);
            k++;
        end
        rx_ready = 0;
        check({name, "_drained"}, rx_exp.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        step(2);
        check("rst_tx_ready", int'(tx_ready), 1);
        check("rst_rx_valid", int'(rx_valid), 0);
        check("rst_levels", int'({tx_level, rx_level}), 0);
        check("rst_active", int'(active), 0);
        check("rst_flags", int'({overflow, error}), 0);
        check("rst_spi", int'({spi_start, spi_data_in}), 0);
        check("rst_rx_data", int'(rx_data), 0);
        rst = 1;
        step(1);

        enable = 1;
        s0 = starts;
        push(8'hA5);
        push(8'h3C);
        wait_rx("burst", 2, 100);
        check("burst_starts", starts - s0, 2);
        check("burst_tx_level", int'(tx_level), 0);
        check("burst_rx_level", int'(rx_level), rx_exp.size());
        check("burst_rx_head", int'(rx_data), 8'h5A);
        drain("burst");

        enable = 0;
        for (int i = 0; i < 9; i++) begin
            check("ovf_tx_ready", int'(tx_ready), int'(tx_exp.size() < DEPTH));
            push(8'(i + 16));
        end
        check("ovf_tx_level", int'(tx_level), DEPTH);
        check("ovf_flag", int'(overflow), 1);
        flush = 1;
        step(1);
        flush = 0;
        tx_exp.delete();
        rx_exp.delete();
        check("flush_tx_level", int'(tx_level), tx_exp.size());
        check("flush_overflow", int'(overflow), 0);
        check("flush_tx_ready", int'(tx_ready), 1);

        enable = 1;
        for (int i = 0; i < 8; i++) push(8'($urandom));
        wait_rx("fill", 8, 300);
        check("fill_rx_level", int'(rx_level), rx_exp.size());
        s0 = starts;
        push(8'hE7);
        step(20);
        check("full_no_start", starts - s0, 0);
        check("full_tx_level", int'(tx_level), 1);
        rx_ready = 1;
        step(1);
        rx_ready = 0;
        wait_rx("refill", 8, 100);
        check("refill_starts", starts - s0, 1);
        check("refill_rx_level", int'(rx_level), rx_exp.size());
        check("refill_tx_level", int'(tx_level), 0);
        drain("refill");

        core_delay = 12;
        store_resp = 0;
        resp_77 = 1;
        s0 = starts;
        push(8'h96);
        n = 0;
        while (starts == s0 && n < 50) begin step(1); n++; end
        check("fw_started", starts - s0, 1);
        push(8'h11);
        push(8'h22);
        check("fw_pre_tx_level", int'(tx_level), 2);
        flush = 1;
        step(1);
        flush = 0;
        tx_exp.delete();
        rx_exp.delete();
        check("fw_tx_level", int'(tx_level), 0);
        check("fw_rx_level", int'(rx_level), 0);
        check("fw_discarding", int'(active), 1);
        n = 0;
        while (spi_busy && n < 50) begin step(1); n++; end
        step(1);
        check("fw_idle", int'(active), 0);
        check("fw_rx_valid", int'(rx_valid), 0);
        check("fw_no_launch", starts - s0, 1);
        store_resp = 1;
        resp_77 = 0;

        s0 = starts;
        push(8'h69);
        n = 0;
        while (starts == s0 && n < 50) begin step(1); n++; end
        push(8'h0F);
        step(1);
        check("ar_pre_active", int'(active), 1);
        check("ar_pre_data", int'(spi_data_in), 8'h69);
        #2;
        rst = 0;
        #1;
        check("ar_active", int'(active), 0);
        check("ar_levels", int'({tx_level, rx_level}), 0);
        check("ar_tx_ready", int'(tx_ready), 1);
        check("ar_spi", int'({spi_start, spi_data_in}), 0);
        check("ar_rx", int'({rx_valid, rx_data}), 0);
        tx_exp.delete();
        rx_exp.delete();
        step(3);
        rst = 1;
        step(2);
        core_delay = 2;

        for (int c = 0; c < 400; c++) begin
            enable = ($urandom_range(0, 3) != 0);
            rx_ready = 1'($urandom_range(0, 1));
            core_delay = $urandom_range(1, 4);
            if (tx_exp.size() < DEPTH) check("rand_tx_ready", int'(tx_ready), 1);
            if ($urandom_range(0, 1) == 1 && tx_exp.size() < DEPTH) begin
                tx_valid = 1;
                tx_data = 8'($urandom);
                tx_exp.push_back(tx_data);
            end else tx_valid = 0;
            step(1);
        end
        tx_valid = 0;
        enable = 1;
        rx_ready = 1;
        n = 0;
        while ((tx_exp.size() != 0 || active || spi_busy || rx_valid) && n < 1000) begin step(1); n++; end
        rx_ready = 0;
        check("rand_done", int'(n < 1000), 1);
        check("rand_rx_left", rx_exp.size(), 0);
        check("rand_tx_level", int'(tx_level), 0);

`ifdef SPI_SEQ_TIMEOUT_EN
        core_hang = 1;
        s0 = starts;
        push(8'h5C);
        n = 0;
        while (!error && n < 60) begin step(1); n++; end
        check("to_cycles", cyc - start_cyc, 16);
        check("to_idle", int'(active), 0);
        push(8'hC5);
        step(20);
        check("to_blocked", starts - s0, 1);
        check("to_tx_level", int'(tx_level), 1);
        check("to_error_sticky", int'(error), 1);
        flush = 1;
        step(1);
        flush = 0;
        tx_exp.delete();
        check("to_flush_error", int'(error), 0);
        core_hang = 0;
        push(8'hAB);
        wait_rx("to_recover", 1, 100);
        check("to_recover_starts", starts - s0, 2);
        drain("to_recover");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_burst_sequencer.md
Name: spi_burst_sequencer

Overview:
Byte-stream front end placed directly upstream of the SPI master core. It holds a TX byte FIFO and an RX byte FIFO, and for each queued TX byte drives the core's data_in/start handshake. It captures the core's data_out on new_data into the RX FIFO. The j1 peripheral decoder can then queue a burst of bytes without polling busy per byte.

Parameters:
DEPTH, 8, entries in each FIFO (power of 2, >=2)
AW, 3, log2(DEPTH); pointer width (level counters are AW+1 bits)
TIMEOUT, 1024, cycles allowed from spi_start to spi_new_data (used only with the optional feature)

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  asynchronous, active-low reset
tx_data  in  8  byte to queue for transmission
tx_valid  in  1  push request for tx_data
tx_ready  out  1  TX FIFO not full
rx_data  out  8  head of RX FIFO (valid while rx_valid)
rx_valid  out  1  RX FIFO not empty
rx_ready  in  1  pop request for RX FIFO
enable  in  1  allows new transfers to launch
flush  in  1  clears both FIFOs; single-cycle pulse
spi_data_in  out  8  byte to core
spi_start  out  1  one-cycle start pulse to core
spi_busy  in  1  core busy
spi_new_data  in  1  core one-cycle "byte received" pulse
spi_data_out  in  8  byte received by core
tx_level  out  AW+1  TX occupancy 0..DEPTH
rx_level  out  AW+1  RX occupancy 0..DEPTH
active  out  1  FSM not in IDLE
overflow  out  1  sticky: tx_valid asserted while TX full
error  out  1  sticky timeout flag (tied 0 without the optional feature)

Behaviour:
- Reset (rst=0, async): both FIFOs empty, levels 0, FSM IDLE, spi_start=0, spi_data_in=0, rx_data=0, flags 0, tx_ready=1, rx_valid=0.
- FIFOs:
  - Push when valid and not full; a push to a full FIFO is dropped.
  - Simultaneous push+pop on a full FIFO is allowed (level unchanged). Simultaneous push+pop on an empty FIFO does not pop.
  - Pointers wrap modulo DEPTH.
  - rx_data is registered from the head entry, so it is valid the cycle rx_valid is high.
- FSM states: IDLE, LOAD, START, WAIT, DISCARD.
  - IDLE -> LOAD when enable && tx_level!=0 && rx_level!=DEPTH && !spi_busy.
  - LOAD: pop TX; spi_data_in <= popped byte (held stable until next LOAD).
  - START: spi_start=1 for exactly this cycle -> WAIT.
  - WAIT: on spi_new_data, push spi_data_out into RX -> IDLE. RX space is guaranteed by the launch condition.
  - Pipeline overhead is 3 cycles (IDLE->LOAD->START) before the core starts; back-to-back bytes re-enter LOAD the cycle after returning to IDLE.
- flush:
  - Clears both FIFOs and both levels the same cycle; it wins over a simultaneous push/pop.
  - In LOAD/START the FSM goes to IDLE and spi_start is suppressed.
  - In WAIT the FSM goes to DISCARD; the next spi_new_data is consumed and not stored, then IDLE.
- Deasserting enable mid-transfer completes the current byte, then holds in IDLE.
- overflow and error clear only on reset or flush.
- spi_new_data outside WAIT/DISCARD is ignored.

Optional Feature:
SPI_SEQ_TIMEOUT_EN:
- Defined: a cycle counter starts at START. If spi_new_data has not arrived TIMEOUT cycles after spi_start, the FSM sets error and goes to IDLE, storing nothing. The timed-out byte is lost. Launching stays blocked while error=1, until flush.
- Undefined: no counter; WAIT is unbounded; error tied 0.

Decomposition:
- Package spi_seq_pkg holds the FSM state encoding constants and the default DEPTH/TIMEOUT.
- One sub-module, spi_seq_fifo (parameterised byte FIFO with level, push/pop, flush), instantiated twice for TX and RX.

Test Plan:
- Push 0xA5,0x3C with enable=1; core model echoes ~byte -> spi_start pulses twice (1 cycle each), spi_data_in 0xA5 then 0x3C, RX holds 0x5A,0xC3, tx_level 0, rx_level 2.
- Push 9 bytes with enable=0, DEPTH=8 -> tx_ready low after 8, 9th dropped, overflow=1, tx_level=8.
- RX filled to 8 with rx_ready=0, TX has 1 byte -> no spi_start issued. Pop one RX -> transfer launches, rx_level returns to 8.
- flush during WAIT -> levels 0. Next spi_new_data (0x77) is not stored, FSM IDLE, rx_valid=0.
- Async reset asserted mid-WAIT -> all outputs at reset values immediately, without a clock edge.
- With SPI_SEQ_TIMEOUT_EN, TIMEOUT=16, core never returns new_data -> error=1 at 16 cycles after spi_start, FSM IDLE, no further launches until flush.
